brightness_writeback: RTL

- Downstream stage of the TPU system that consumes the four row-3 normalized outputs (pe30..pe33 norm, 16-bit each).
- Deskews the systolic diagonal so that one output row is assembled from four different cycles.
- Saturates each value to an 8-bit pixel, buffers completed rows, and writes the pixels byte-serially into the output image RAM (64 x 8, 6-bit address).
- Signals frame completion to the top-level sequencer.

---
 rtl/brightness_wb_pkg.sv | 30 +++
 rtl/brightness_writeback_fifo.sv | 54 +++++
 rtl/brightness_writeback.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/brightness_wb_pkg.sv
// Shared types for the brightness write-back stage.
//   wb_state_t  : frame sequencer states
//   row_entry_t : one assembled output row (row index + four 8-bit pixels)
//   saturate()  : clamp an unsigned normalized value to an 8-bit pixel
package brightness_wb_pkg;

  localparam int PIX_W   = 8;
  localparam int NORM_W  = 16;
  localparam int NUM_PIX = 4;
  localparam int IDX_W   = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } wb_state_t;

  // pix[0] is column 0 (pe30), pix[3] is column 3 (pe33)
  typedef struct packed {
    logic [IDX_W-1:0]                  row_idx;
    logic [NUM_PIX-1:0][PIX_W-1:0]     pix;
  } row_entry_t;

  function automatic logic [PIX_W-1:0] saturate(input logic [NORM_W-1:0] v,
                                                input logic [NORM_W-1:0] sat_max);
    return (v > sat_max) ? sat_max[PIX_W-1:0] : v[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/brightness_writeback_fifo.sv
// wb_row_fifo: synchronous FIFO of assembled rows.
//   clk, reset        : clock, async active-low reset (pointers only)
//   push / push_data  : enqueue; ignored when full unless a pop happens too
//   pop  / pop_data   : dequeue; pop_data is the head entry (combinational)
//   full, empty       : occupancy flags
// A push and a pop in the same cycle while full is legal: the head is read
// out this cycle and its slot is rewritten at the same edge.
module wb_row_fifo
  import brightness_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  row_entry_t push_data,
  input  logic       pop,
  output row_entry_t pop_data,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] PTR_ONE = 1;

  // one extra pointer bit distinguishes full from empty
  logic [PTR_W:0] wr_ptr, rd_ptr;
  row_entry_t     mem [DEPTH];
  logic           wr_ok, rd_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign rd_ok = pop && !empty;
  assign wr_ok = push && (!full || rd_ok);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/brightness_writeback.sv
// brightness_writeback: consumes the row-3 normalized outputs of the systolic
// array, deskews the diagonal into whole rows, saturates to 8-bit pixels,
// buffers rows and writes them byte-serially into the output image RAM.
//   clk, reset            : clock, async active-low reset
//   start                 : one-cycle frame start (honoured in IDLE / DONE)
//   row_valid             : pe30 value of a new row is valid this cycle
//   pe3j_norm_in          : column j value, valid j cycles after row_valid
//   wr_en/wr_addr/wr_data : output RAM write port
//   busy                  : COLLECT or DRAIN
//   done                  : frame complete, held until next start
//   overflow              : sticky, a row was dropped on a full FIFO
//   rows_accepted         : rows taken in the current frame
module brightness_writeback
  import brightness_wb_pkg::*;
#(
  parameter int NUM_ROWS   = 16,
  parameter int ADDR_W     = 6,
  parameter int FIFO_DEPTH = 4,
  parameter int SAT_MAX    = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              row_valid,
  input  logic [NORM_W-1:0] pe30_norm_in,
  input  logic [NORM_W-1:0] pe31_norm_in,
  input  logic [NORM_W-1:0] pe32_norm_in,
  input  logic [NORM_W-1:0] pe33_norm_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [4:0]        rows_accepted
);

  // registered deskew stages; the last column joins combinationally at push
  localparam int STAGES = NUM_PIX - 2;
  localparam logic [4:0]        ROWS_MAX = 5'(NUM_ROWS);
  localparam logic [NORM_W-1:0] SAT_VAL  = NORM_W'(SAT_MAX);

  wb_state_t state, state_nxt;

  logic [NUM_PIX-1:0][NORM_W-1:0] norm_in;
  logic [NUM_PIX-1:0][PIX_W-1:0]  sat_pix;

  logic                                  accept, start_frame;
  logic [STAGES:0]                       vld_pipe;
  logic [STAGES:0][IDX_W-1:0]            idx_pipe;
  logic [STAGES:0][NUM_PIX-1:0][PIX_W-1:0] pix_pipe;

  row_entry_t push_entry, pop_entry, wr_row;
  logic       push_req, fifo_pop, fifo_full, fifo_empty, drop;
  logic       wr_active;
  logic [1:0] wr_cnt;

  // ---------------------------------------------------------------- saturate
  assign norm_in = {pe33_norm_in, pe32_norm_in, pe31_norm_in, pe30_norm_in};

  genvar j;
  generate
    for (j = 0; j < NUM_PIX; j++) begin : g_sat
      assign sat_pix[j] = saturate(norm_in[j], SAT_VAL);
    end
  endgenerate

  assign start_frame = start && ((state == IDLE) || (state == DONE));
  assign accept      = (state == COLLECT) && row_valid && (rows_accepted < ROWS_MAX);

  // ------------------------------------------------------------------ deskew
  // Stage s holds columns 0..s of one row; each row picks up column s+1 one
  // cycle later, so up to four rows are in flight on back-to-back row_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
      idx_pipe <= '0;
      pix_pipe <= '0;
    end else begin
      vld_pipe       <= {vld_pipe[STAGES-1:0], accept};
      idx_pipe[0]    <= rows_accepted[IDX_W-1:0];
      pix_pipe[0]    <= '0;
      pix_pipe[0][0] <= sat_pix[0];
      for (int s = 1; s <= STAGES; s++) begin
        idx_pipe[s]    <= idx_pipe[s-1];
        pix_pipe[s]    <= pix_pipe[s-1];
        pix_pipe[s][s] <= sat_pix[s];
      end
    end
  end

  assign push_req = vld_pipe[STAGES];

  always_comb begin
    push_entry                   = '0;
    push_entry.row_idx           = idx_pipe[STAGES];
    push_entry.pix               = pix_pipe[STAGES];
    push_entry.pix[NUM_PIX-1]    = sat_pix[NUM_PIX-1];
  end

  // a pop in the same cycle frees the slot, so only a non-popping full FIFO drops
  assign drop = push_req && fifo_full && !fifo_pop;

  wb_row_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .pop_data  (pop_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // ------------------------------------------------------------------ writer
  // Pop on the last byte of the current row so rows stream without a gap.
  assign fifo_pop = !fifo_empty && (!wr_active || (wr_cnt == 2'd3));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_active <= 1'b0;
      wr_cnt    <= '0;
      wr_row    <= '0;
    end else if (fifo_pop) begin
      wr_active <= 1'b1;
      wr_cnt    <= '0;
      wr_row    <= pop_entry;
    end else if (wr_active) begin
      if (wr_cnt == 2'd3) wr_active <= 1'b0;
      wr_cnt <= wr_cnt + 2'd1;
    end
  end

  assign wr_en   = wr_active;
  assign wr_addr = wr_active ? ADDR_W'({wr_row.row_idx, wr_cnt}) : '0;
  assign wr_data = wr_active ? wr_row.pix[wr_cnt] : '0;

  // ---------------------------------------------------------------- counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rows_accepted <= '0;
      overflow      <= 1'b0;
    end else if (start_frame) begin
      rows_accepted <= '0;
      overflow      <= 1'b0;
    end else begin
      if (accept) rows_accepted <= rows_accepted + 5'd1;
      if (drop)   overflow      <= 1'b1;
    end
  end

  // --------------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = COLLECT;
      // the oldest tag is pushed this cycle; nothing younger remains in flight
      COLLECT: if ((rows_accepted == ROWS_MAX) && (vld_pipe[STAGES-1:0] == '0))
                 state_nxt = DRAIN;
      DRAIN:   if (fifo_empty && !wr_active) state_nxt = DONE;
      DONE:    if (start) state_nxt = COLLECT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == COLLECT) || (state == DRAIN);
    done = (state == DONE);
  end

endmodule
